// File: rtl/ext_bus_pkg.sv
// Shared types for the external memory bus sequencer: FSM states, requester ids, default widths.
// Pure declarations, no logic or latency; backpressure is handled by the modules that import it.
package ext_bus_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 16;

    // Requester ids double as bit positions in the arbiter request vector.
    localparam logic REQ_FETCH = 1'b0;
    localparam logic REQ_DATA  = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/external_bus_arbiter_rr.sv
// Two-requester round-robin grant; on a tie the requester opposite the previous winner is chosen.
// Grant is combinational from i_req; last_grant updates on the edge where i_grant_en accepts it.
// No backpressure: requesters simply hold i_req until they are served.
module rr_arbiter_2
    import ext_bus_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_req,
    input  logic       i_grant_en,
    output logic       o_grant_vld,
    output logic       o_grant_id
);

    logic last_grant;

    assign o_grant_vld = |i_req;

    always_comb begin
        o_grant_id = REQ_FETCH;
        if (&i_req)
            o_grant_id = ~last_grant;
        else if (i_req[REQ_DATA])
            o_grant_id = REQ_DATA;
    end

    // Reset to DATA so that fetch wins the first tie after reset.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            last_grant <= REQ_DATA;
        else if (i_grant_en && o_grant_vld)
            last_grant <= o_grant_id;
    end

endmodule

// File: rtl/external_bus_arbiter.sv
// Sequences the shared ROM/RAM bus between the fetch and data requesters, one access at a time.
// Latency: request seen in IDLE at t -> strobes t+1..t+WAIT_CYCLES -> ack at t+WAIT_CYCLES+1.
// Backpressure: level requests are held until their one-cycle ack; requests are ignored while busy.
module external_bus_arbiter
    import ext_bus_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_fetch_req,
    input  logic [ADDR_W-1:0] i_fetch_addr,
    output logic              o_fetch_ack,
    output logic [DATA_W-1:0] o_fetch_data,
    input  logic              i_data_req,
    input  logic              i_data_we,
    input  logic [ADDR_W-1:0] i_data_addr,
    input  logic [DATA_W-1:0] i_data_wdata,
    output logic              o_data_ack,
    output logic [DATA_W-1:0] o_data_rdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_rom_read,
    output logic              o_ram_read,
    output logic              o_ram_write,
    input  logic [DATA_W-1:0] i_rom_rdata,
    input  logic [DATA_W-1:0] i_ram_rdata,
    output logic              o_busy
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    if (WAIT_CYCLES < 1) begin : g_bad_wait
        $error("external_bus_arbiter: WAIT_CYCLES must be at least 1");
    end

    state_t     state;
    logic [CNT_W-1:0] wait_cnt;
    logic       gnt_id_q;
    logic       grant_vld;
    logic       grant_id;

    rr_arbiter_2 u_rr (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req       ({i_data_req, i_fetch_req}),
        .i_grant_en  (state == IDLE),
        .o_grant_vld (grant_vld),
        .o_grant_id  (grant_id)
    );

    // The bus output registers double as the latched address/wdata of the granted access.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            gnt_id_q     <= REQ_FETCH;
            o_fetch_ack  <= 1'b0;
            o_fetch_data <= '0;
            o_data_ack   <= 1'b0;
            o_data_rdata <= '0;
            o_mem_addr   <= '0;
            o_mem_wdata  <= '0;
            o_rom_read   <= 1'b0;
            o_ram_read   <= 1'b0;
            o_ram_write  <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            o_fetch_ack <= 1'b0;
            o_data_ack  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        state    <= ACCESS;
                        o_busy   <= 1'b1;
                        gnt_id_q <= grant_id;
                        wait_cnt <= CNT_W'(WAIT_CYCLES - 1);
                        if (grant_id == REQ_FETCH) begin
                            o_mem_addr <= i_fetch_addr;
                            o_rom_read <= 1'b1;
                        end else begin
                            o_mem_addr  <= i_data_addr;
                            o_ram_read  <= ~i_data_we;
                            o_ram_write <= i_data_we;
                            o_mem_wdata <= i_data_we ? i_data_wdata : '0;
                        end
                    end
                end
                ACCESS: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end else begin
                        state       <= DONE;
                        o_mem_addr  <= '0;
                        o_mem_wdata <= '0;
                        o_rom_read  <= 1'b0;
                        o_ram_read  <= 1'b0;
                        o_ram_write <= 1'b0;
                        if (gnt_id_q == REQ_FETCH) begin
                            o_fetch_ack  <= 1'b1;
                            o_fetch_data <= i_rom_rdata;
                        end else begin
                            o_data_ack <= 1'b1;
                            if (o_ram_read)
                                o_data_rdata <= i_ram_rdata;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/external_bus_arbiter.md
Name: external_bus_arbiter

Overview:
- Sequences the shared external memory bus (8-bit address, 16-bit data) between two requesters: the instruction-fetch path (PC/IR side) and the data path (MAR/MBR side).
- Fetches always target ROM; data reads and writes always target RAM.
- Owns the ROM/RAM strobes and the access wait-state timing, and returns read data through a req/ack handshake.
- Sits between the CPU control unit and the ROM/RAM models, replacing ad-hoc strobe generation from control signals.

Parameters:
- ADDR_W, 8, memory address width.
- DATA_W, 16, memory data width.
- WAIT_CYCLES, 1, cycles the memory strobe is held per access; must be >=1 (elaboration-time check; 0 is illegal).

Ports:
- i_clk  input  1  clock
- i_rst  input  1  synchronous active-high reset
- i_fetch_req  input  1  fetch request, level, held until ack
- i_fetch_addr  input  ADDR_W  ROM address
- o_fetch_ack  output  1  one-cycle completion pulse
- o_fetch_data  output  DATA_W  captured ROM word
- i_data_req  input  1  data request, level, held until ack
- i_data_we  input  1  1=RAM write, 0=RAM read
- i_data_addr  input  ADDR_W  RAM address
- i_data_wdata  input  DATA_W  RAM write data
- o_data_ack  output  1  one-cycle completion pulse
- o_data_rdata  output  DATA_W  captured RAM word
- o_mem_addr  output  ADDR_W  bus address
- o_mem_wdata  output  DATA_W  bus write data
- o_rom_read  output  1  ROM read strobe
- o_ram_read  output  1  RAM read strobe
- o_ram_write  output  1  RAM write strobe
- i_rom_rdata  input  DATA_W  ROM read data
- i_ram_rdata  input  DATA_W  RAM read data
- o_busy  output  1  high in any state other than IDLE

Behaviour:
- Reset:
  - Synchronous and active-high, dominant over all other activity.
  - All outputs reset to 0; state goes to IDLE; wait counter cleared.
  - last_grant resets to DATA, so fetch wins the first tie.
- FSM states are IDLE, ACCESS and DONE. All outputs are registered or decoded from registered state; there are no combinational paths from inputs to outputs.
- IDLE:
  - Samples both requests.
  - If neither request is high, the FSM stays in IDLE.
  - If exactly one is high, that requester is granted.
  - If both are high, the requester opposite last_grant is granted (2-way round-robin).
  - On grant: latch requester id, address, we and wdata; load counter = WAIT_CYCLES-1; update last_grant; go to ACCESS.
- ACCESS:
  - o_mem_addr = latched address.
  - Exactly one strobe is high, held for every ACCESS cycle:
    - fetch: o_rom_read
    - data read: o_ram_read
    - data write: o_ram_write
  - o_mem_wdata = latched wdata for writes only; 0 otherwise.
  - If counter != 0, decrement it.
  - If counter == 0 (last ACCESS cycle), capture read data (i_rom_rdata into o_fetch_data, or i_ram_rdata into o_data_rdata; no capture on writes) and go to DONE.
- DONE:
  - All strobes are 0; o_mem_addr and o_mem_wdata are 0.
  - The granted requester's ack is 1 for exactly this cycle.
  - Next state is IDLE unconditionally. Requests are not sampled in DONE.
- Outside ACCESS, o_mem_addr, o_mem_wdata and all strobes are 0 (the bus is parked at zero).
- Latency: request sampled in cycle t → strobes high in t+1..t+WAIT_CYCLES → ack at t+WAIT_CYCLES+1 → earliest next grant at t+WAIT_CYCLES+2.
- Handshake rules:
  - A requester keeps req, addr, we and wdata stable until it samples ack.
  - It clears req on the edge at which it samples ack=1, so req is already low in the following IDLE cycle.
  - If req is still high in that IDLE cycle, it is treated as a new request.
  - Address and data changes after the grant are ignored because they are latched.
- Read-data registers hold their value until the next read by the same requester. A data write never alters o_data_rdata.
- Reset asserted mid-ACCESS or in DONE:
  - Strobes are 0 on the next cycle; no ack is issued; any pending capture is discarded.
  - Requesters must re-issue their requests.
- Only one access is ever outstanding; the two strobes are never high simultaneously. Verification asserts both invariants.

Decomposition:
- Shared package ext_bus_pkg holds:
  - the state enum (IDLE, ACCESS, DONE)
  - requester id constants (REQ_FETCH, REQ_DATA)
  - default ADDR_W and DATA_W
- Optional sub-module rr_arbiter_2: a two-requester round-robin grant with last_grant state and a grant-enable input, reusable elsewhere. All other logic stays inline.

Test Plan:
- Reset: i_rst high for 2 cycles with both requests high → all outputs 0, o_busy 0, no strobe.
- Fetch, WAIT_CYCLES=2: fetch addr 0x10, i_rom_rdata=0xABCD, request in cycle 0 → o_rom_read=1 and o_mem_addr=0x10 in cycles 1–2; o_fetch_ack=1 in cycle 3; o_fetch_data=0xABCD.
- Data write: addr 0x22, wdata 0x1234 → o_ram_write=1 with o_mem_wdata=0x1234 for WAIT_CYCLES cycles; o_ram_read stays 0; o_data_ack pulses once; o_data_rdata unchanged.
- Contention: both requests high from reset, each re-asserted after its ack → grant order fetch, data, fetch, data; gap between consecutive grants is WAIT_CYCLES+2 cycles.
- Reset during the 2nd ACCESS cycle of a RAM read → strobes 0 next cycle; no o_data_ack; a following data read of addr 0x05 with i_ram_rdata=0x00FF completes normally with 0x00FF.
- Isolation: fetch returns 0x1111, then data read returns 0x00FF → o_fetch_data stays 0x1111; exactly one ack per request; strobes never overlap.
